// File: rtl/nvdla_periph_master_pkg.sv
// Shared definitions for the NVDLA peripheral-bus job initiator: register
// offsets inside the HWPE register file, FSM states, completion error codes
// and the request descriptor carried to the bus request port.
package nvdla_periph_master_pkg;

   // Register offsets relative to the HWPE register file base
   localparam logic [31:0] REG_TRIGGER = 32'h0000_0000;
   localparam logic [31:0] REG_ACQUIRE = 32'h0000_0004;
   localparam logic [31:0] REG_GENERIC = 32'h0000_0040;

   // ACQUIRE read data: bit 31 set means no context is free yet
   localparam int ACQ_BUSY_BIT = 31;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACQ_REQ,
      ST_ACQ_WAIT,
      ST_WR_REG,
      ST_TRIG,
      ST_WAIT_EVT,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK        = 2'd0,
      ERR_ACQ_RETRY = 2'd1,
      ERR_TIMEOUT   = 2'd2
   } err_t;

   // One bus request: byte address, direction (1 = read) and write data
   typedef struct packed {
      logic [31:0] add;
      logic        wen;
      logic [31:0] data;
   } bus_req_t;

   // What the bus shows when no request is outstanding
   localparam bus_req_t IDLE_REQ = '{add: 32'h0, wen: 1'b1, data: 32'h0};

   // Byte offset of generic job register idx
   function automatic logic [31:0] generic_off(input logic [31:0] idx);
      return REG_GENERIC + (idx << 2);
   endfunction

endpackage

// File: rtl/nvdla_periph_req_port.sv
// Request slot of the peripheral bus initiator. A request is loaded by a
// one-cycle issue strobe and its fields are frozen until the grant is sampled.
// A new request may be loaded in the same cycle the current one is granted,
// which gives back-to-back transfers without an idle bubble.
module nvdla_periph_req_port
   import nvdla_periph_master_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     issue,
   input  bus_req_t next_req,
   input  logic     gnt,
   output logic     req,
   output bus_req_t cur
);

   // Load when the slot is empty or being granted; otherwise hold until grant
   always_ff @(posedge clk) begin
      if (rst) begin
         req <= 1'b0;
         cur <= IDLE_REQ;
      end else if (issue && (!req || gnt)) begin
         req <= 1'b1;
         cur <= next_req;
      end else if (req && gnt) begin
         req <= 1'b0;
         cur <= IDLE_REQ;
      end
   end

endmodule

// File: rtl/nvdla_periph_master.sv
// Peripheral-bus initiator that runs one NVDLA HWPE job at a time: acquire a
// context, write the generic job registers, write TRIGGER, then wait for the
// completion event (or time out) and report the context ID and status.
module nvdla_periph_master
   import nvdla_periph_master_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int          N_IO_REGS      = 8,
   parameter int          ID_WIDTH       = 10,
   parameter int          TIMEOUT_CYCLES = 65535,
   parameter int          MAX_ACQ_RETRY  = 15
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    job_valid_i,
   output logic                    job_ready_o,
   input  logic [N_IO_REGS*32-1:0] job_regs_i,
   output logic                    done_valid_o,
   output logic [7:0]              done_job_id_o,
   output logic [1:0]              done_err_o,
   output logic                    busy_o,
   output logic                    periph_req_o,
   input  logic                    periph_gnt_i,
   output logic [31:0]             periph_add_o,
   output logic                    periph_wen_o,
   output logic [3:0]              periph_be_o,
   output logic [31:0]             periph_data_o,
   output logic [ID_WIDTH-1:0]     periph_id_o,
   input  logic                    periph_r_valid_i,
   input  logic [31:0]             periph_r_data_i,
   input  logic [ID_WIDTH-1:0]     periph_r_id_i,
   input  logic                    evt_i
);

   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RT_W  = $clog2(MAX_ACQ_RETRY + 1);
   localparam int IDX_W = (N_IO_REGS > 1) ? $clog2(N_IO_REGS) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IO_REGS - 1);
   localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
   localparam logic [RT_W-1:0]  RT_LIMIT = RT_W'(MAX_ACQ_RETRY);

   state_t           state, state_n;
   err_t             err, err_n;
   logic [RT_W-1:0]  retry, retry_n, retry_inc;
   logic [TO_W-1:0]  tcnt, tcnt_n, tcnt_inc;
   logic [IDX_W-1:0] idx, idx_n;
   logic [7:0]       job_id, job_id_n;
   logic [31:0]      regs [N_IO_REGS];
   logic             issue, take_rsp, rsp_ok, req;
   bus_req_t         next_req, cur;
   logic             unused_rdata;

   function automatic bus_req_t make_read(input logic [31:0] a);
      bus_req_t r;
      r.add  = a;
      r.wen  = 1'b1;
      r.data = 32'h0;
      return r;
   endfunction

   function automatic bus_req_t make_write(input logic [31:0] a, input logic [31:0] d);
      bus_req_t r;
      r.add  = a;
      r.wen  = 1'b0;
      r.data = d;
      return r;
   endfunction

   // Cycle counter increment that sticks at the limit instead of wrapping
   function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
      return (v == TO_LIMIT) ? v : v + TO_W'(1);
   endfunction

   assign retry_inc = retry + RT_W'(1);
   assign tcnt_inc  = sat_inc(tcnt);

   // Only ACQUIRE responses tagged with our (constant zero) ID are ours
   assign rsp_ok = periph_r_valid_i && (periph_r_id_i == '0);

   // Only the busy flag and the context ID field of ACQUIRE data are meaningful
   assign unused_rdata = ^periph_r_data_i[30:8];

   // Next-state logic; bus requests are issued on the transition into the
   // state that owns them so they appear on the bus the following cycle
   always_comb begin
      state_n  = state;
      err_n    = err;
      retry_n  = retry;
      tcnt_n   = tcnt;
      idx_n    = idx;
      job_id_n = job_id;
      issue    = 1'b0;
      next_req = IDLE_REQ;
      take_rsp = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (job_valid_i) begin
               state_n  = ST_ACQ_REQ;
               err_n    = ERR_OK;
               retry_n  = '0;
               tcnt_n   = '0;
               idx_n    = '0;
               job_id_n = '0;
               issue    = 1'b1;
               next_req = make_read(BASE_ADDR + REG_ACQUIRE);
            end
         end
         ST_ACQ_REQ: begin
            // A response arriving together with its grant is consumed here
            if (periph_gnt_i) begin
               state_n  = ST_ACQ_WAIT;
               take_rsp = rsp_ok;
            end
         end
         ST_ACQ_WAIT: begin
            take_rsp = rsp_ok;
         end
         ST_WR_REG: begin
            if (periph_gnt_i) begin
               if (idx == LAST_IDX) begin
                  state_n  = ST_TRIG;
                  issue    = 1'b1;
                  next_req = make_write(BASE_ADDR + REG_TRIGGER, 32'h0);
               end else begin
                  idx_n    = idx + IDX_W'(1);
                  issue    = 1'b1;
                  next_req = make_write(BASE_ADDR + generic_off(32'(idx_n)), regs[idx_n]);
               end
            end
         end
         ST_TRIG: begin
            if (periph_gnt_i) begin
               tcnt_n  = '0;
               state_n = ST_WAIT_EVT;
            end
         end
         ST_WAIT_EVT: begin
            // The event takes priority over a timeout in the same cycle
            if (evt_i) begin
               state_n = ST_DONE;
               err_n   = ERR_OK;
            end else begin
               tcnt_n = tcnt_inc;
               if (tcnt_inc == TO_LIMIT) begin
                  state_n = ST_DONE;
                  err_n   = ERR_TIMEOUT;
               end
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      if (take_rsp) begin
         if (!periph_r_data_i[ACQ_BUSY_BIT]) begin
            job_id_n = periph_r_data_i[7:0];
            idx_n    = '0;
            state_n  = ST_WR_REG;
            issue    = 1'b1;
            next_req = make_write(BASE_ADDR + generic_off(32'h0), regs[0]);
         end else begin
            retry_n = retry_inc;
            if (retry_inc == RT_LIMIT) begin
               state_n = ST_DONE;
               err_n   = ERR_ACQ_RETRY;
            end else begin
               state_n  = ST_ACQ_REQ;
               issue    = 1'b1;
               next_req = make_read(BASE_ADDR + REG_ACQUIRE);
            end
         end
      end
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Job context: counters, register index, granted ID and completion status
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err    <= ERR_OK;
         retry  <= '0;
         tcnt   <= '0;
         idx    <= '0;
         job_id <= '0;
      end else begin
         err    <= err_n;
         retry  <= retry_n;
         tcnt   <= tcnt_n;
         idx    <= idx_n;
         job_id <= job_id_n;
      end
   end

   // Capture the job descriptor when a job is accepted
   always_ff @(posedge clk_i) begin
      if (state == ST_IDLE && job_valid_i) begin
         for (int i = 0; i < N_IO_REGS; i++) begin
            regs[i] <= job_regs_i[32*i +: 32];
         end
      end
   end

   nvdla_periph_req_port u_req_port (
      .clk      (clk_i),
      .rst      (rst_i),
      .issue    (issue),
      .next_req (next_req),
      .gnt      (periph_gnt_i),
      .req      (req),
      .cur      (cur)
   );

   assign job_ready_o   = (state == ST_IDLE);
   assign busy_o        = (state != ST_IDLE);
   assign done_valid_o  = (state == ST_DONE);
   assign done_job_id_o = job_id;
   assign done_err_o    = err;

   assign periph_req_o  = req;
   assign periph_add_o  = cur.add;
   assign periph_wen_o  = cur.wen;
   assign periph_data_o = cur.data;
   assign periph_be_o   = 4'hF;
   assign periph_id_o   = '0;

endmodule

// File: tb/tb_nvdla_periph_master.sv
// Directed-plus-random bench for nvdla_periph_master. A bus slave model grants,
// answers ACQUIRE reads and fires the completion event; a monitor logs every
// granted transfer and done pulse; each job is compared against a transaction
// list and done record computed from the job description.
module tb_nvdla_periph_master;

   localparam int          N    = 8;
   localparam int          MAXR = 4;
   localparam int          TO   = 20;
   localparam int          IDW  = 10;
   localparam logic [31:0] BASE = 32'h0010_0000;

   logic             clk, rst;
   logic             job_valid, job_ready;
   logic [N*32-1:0]  job_regs;
   logic             done_valid;
   logic [7:0]       done_id;
   logic [1:0]       done_err;
   logic             busy;
   logic             req, gnt, wen;
   logic [31:0]      add, wdata;
   logic [3:0]       be;
   logic [IDW-1:0]   pid, r_id;
   logic             r_valid;
   logic [31:0]      r_data;
   logic             evt;

   nvdla_periph_master #(
      .BASE_ADDR      (BASE),
      .N_IO_REGS      (N),
      .ID_WIDTH       (IDW),
      .TIMEOUT_CYCLES (TO),
      .MAX_ACQ_RETRY  (MAXR)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .job_valid_i      (job_valid),
      .job_ready_o      (job_ready),
      .job_regs_i       (job_regs),
      .done_valid_o     (done_valid),
      .done_job_id_o    (done_id),
      .done_err_o       (done_err),
      .busy_o           (busy),
      .periph_req_o     (req),
      .periph_gnt_i     (gnt),
      .periph_add_o     (add),
      .periph_wen_o     (wen),
      .periph_be_o      (be),
      .periph_data_o    (wdata),
      .periph_id_o      (pid),
      .periph_r_valid_i (r_valid),
      .periph_r_data_i  (r_data),
      .periph_r_id_i    (r_id),
      .evt_i            (evt)
   );

   typedef struct {
      int          cyc;
      logic [31:0] add;
      logic        wen;
      logic [31:0] data;
   } txn_t;

   typedef struct {
      int         cyc;
      logic [7:0] id;
      logic [1:0] err;
   } done_t;

   txn_t        trace[$];
   done_t       dones[$];
   logic [31:0] acq_q[$];
   logic [31:0] acq_list[$];
   logic [N*32-1:0] regs_v;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   stab_err = 0;
   int   t_acc = 0;
   int   gnt_mode = 0;      // 0 always grant, 1 random, 2 refuse writes
   bit   noise_on = 0;
   bit   same_cyc_rsp = 0;
   bit   stray_evt = 0;
   int   evt_delay = 0;     // event in the k-th cycle after TRIGGER grant, 0 = never
   int   evt_cnt = 0;
   int   rsp_wait = 0;
   logic [31:0] rsp_val = 32'h0;
   logic [31:0] acq_val;

   bit          hold_valid = 0;
   logic [31:0] h_add, h_data;
   logic        h_wen;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Bus slave and event source, updated just after each rising edge
   always @(posedge clk) begin
      #1;
      r_valid = 1'b0;
      r_id    = '0;
      r_data  = 32'h0;
      evt     = 1'b0;
      if (rsp_wait > 0) begin
         rsp_wait--;
         if (rsp_wait == 0) begin
            r_valid = 1'b1;
            r_data  = rsp_val;
         end else if (noise_on) begin
            r_valid = 1'b1;
            r_id    = IDW'($urandom_range(1, 1023));
         end
      end else if (noise_on && $urandom_range(0, 3) == 0) begin
         r_valid = 1'b1;
         r_id    = IDW'($urandom_range(1, 1023));
      end
      case (gnt_mode)
         0:       gnt = 1'b1;
         1:       gnt = 1'($urandom_range(0, 1));
         default: gnt = !(req && !wen);
      endcase
      if (evt_cnt > 0) begin
         evt_cnt--;
         if (evt_cnt == 0) evt = 1'b1;
      end
      if (req && gnt) begin
         if (wen) begin
            acq_val = (acq_q.size() > 0) ? acq_q.pop_front() : 32'h8000_0000;
            if (same_cyc_rsp) begin
               r_valid = 1'b1;
               r_id    = '0;
               r_data  = acq_val;
            end else begin
               rsp_val  = acq_val;
               rsp_wait = (gnt_mode == 1) ? $urandom_range(1, 3) : 1;
            end
         end else if (add == BASE) begin
            evt_cnt = evt_delay;
         end else if (add == BASE + 32'h48 && stray_evt) begin
            evt = 1'b1;
         end
      end
   end

   // Monitor: granted transfers, done pulses and request-field stability
   always @(negedge clk) begin
      if (rst) begin
         hold_valid = 0;
      end else begin
         if (req) begin
            if (hold_valid && (add !== h_add || wen !== h_wen || wdata !== h_data)) stab_err++;
            if (be !== 4'hF || pid !== '0) stab_err++;
            if (gnt) begin
               trace.push_back('{cyc, add, wen, wdata});
               hold_valid = 0;
            end else begin
               hold_valid = 1;
               h_add  = add;
               h_wen  = wen;
               h_data = wdata;
            end
         end else begin
            if (hold_valid) stab_err++;
            hold_valid = 0;
         end
         if (done_valid) dones.push_back('{cyc, done_id, done_err});
      end
   end

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic start_job(input string tag);
      trace.delete();
      dones.delete();
      stab_err = 0;
      acq_q = acq_list;
      @(posedge clk);
      #2;
      check({tag, " ready before accept"}, 64'(job_ready), 64'd1);
      job_valid = 1'b1;
      job_regs  = regs_v;
      t_acc     = cyc;
      @(posedge clk);
      #2;
      job_valid = 1'b0;
   endtask

   // Reference: derive expected bus trace and completion from the job description
   task automatic finish_job(input string tag);
      int         exp_reads, exp_off, guard, bad, trig_cyc;
      bit         acq_ok;
      logic [7:0] exp_id;
      logic [1:0] exp_err;
      txn_t       exp_t[$];

      exp_reads = 0;
      acq_ok    = 0;
      exp_id    = 8'h0;
      exp_err   = 2'd1;
      exp_off   = 0;
      for (int r = 0; r < acq_list.size(); r++) begin
         exp_reads++;
         exp_t.push_back('{0, BASE + 32'h4, 1'b1, 32'h0});
         if (!acq_list[r][31]) begin
            acq_ok = 1;
            exp_id = acq_list[r][7:0];
            break;
         end
         if (exp_reads == MAXR) break;
      end
      if (acq_ok) begin
         for (int i = 0; i < N; i++)
            exp_t.push_back('{0, BASE + 32'h40 + 32'(4 * i), 1'b0, regs_v[32*i +: 32]});
         exp_t.push_back('{0, BASE, 1'b0, 32'h0});
         if (evt_delay >= 1 && evt_delay <= TO) begin
            exp_err = 2'd0;
            exp_off = evt_delay + 1;
         end else begin
            exp_err = 2'd2;
            exp_off = TO + 1;
         end
      end

      guard = 0;
      while (dones.size() == 0 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      repeat (4) @(negedge clk);
      check({tag, " done pulses"}, 64'(dones.size()), 64'd1);
      check({tag, " bus transfers"}, 64'(trace.size()), 64'(exp_t.size()));
      bad = 0;
      for (int i = 0; i < exp_t.size() && i < trace.size(); i++) begin
         if (trace[i].add !== exp_t[i].add || trace[i].wen !== exp_t[i].wen) bad++;
         else if (!exp_t[i].wen && trace[i].data !== exp_t[i].data) bad++;
      end
      check({tag, " transfer contents"}, 64'(bad), 64'd0);
      check({tag, " request stability"}, 64'(stab_err), 64'd0);
      if (dones.size() > 0) begin
         check({tag, " done err"}, 64'(dones[0].err), 64'(exp_err));
         if (acq_ok) begin
            check({tag, " done id"}, 64'(dones[0].id), 64'(exp_id));
            trig_cyc = (trace.size() > 0) ? trace[trace.size()-1].cyc : -1000;
            check({tag, " done timing"}, 64'(dones[0].cyc - trig_cyc), 64'(exp_off));
         end
      end
      check({tag, " idle bus"}, {req, wen, add, wdata}, {1'b0, 1'b1, 32'h0, 32'h0});
   endtask

   task automatic do_job(input string tag);
      start_job(tag);
      finish_job(tag);
   endtask

   task automatic rand_regs();
      for (int i = 0; i < N; i++) regs_v[32*i +: 32] = $urandom;
   endtask

   initial begin
      int guard;
      rst       = 1'b1;
      job_valid = 1'b0;
      job_regs  = '0;
      regs_v    = '0;
      repeat (3) @(posedge clk);
      #2;
      check("reset job_ready", 64'(job_ready), 64'd1);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", {done_valid, done_id, done_err}, 64'd0);
      check("reset bus", {req, wen, be, add, wdata}, {1'b0, 1'b1, 4'hF, 32'h0, 32'h0});
      check("reset id", 64'(pid), 64'd0);
      rst = 1'b0;

      // Happy path with exact latency
      for (int i = 0; i < N; i++) regs_v[32*i +: 32] = 32'h10 + 32'(i);
      acq_list  = '{32'h0000_0003};
      evt_delay = 5;
      do_job("happy");
      if (trace.size() == N + 2) begin
         check("happy acquire cycle", 64'(trace[0].cyc - t_acc), 64'd1);
         check("happy first write cycle", 64'(trace[1].cyc - t_acc), 64'd3);
         check("happy trigger cycle", 64'(trace[N+1].cyc - t_acc), 64'(3 + N));
      end else begin
         check("happy trace length for latency", 64'(trace.size()), 64'(N + 2));
      end

      // Random grant stalls, delayed responses and foreign-ID noise
      gnt_mode = 1;
      noise_on = 1;
      for (int j = 0; j < 4; j++) begin
         rand_regs();
         acq_list  = '{$urandom & 32'h7FFF_FFFF};
         evt_delay = $urandom_range(1, 25);
         do_job("stall");
      end
      gnt_mode = 0;
      noise_on = 0;

      // Busy ACQUIRE three times, then success
      rand_regs();
      acq_list  = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001};
      evt_delay = 3;
      do_job("retry");

      // Always busy: retries exhausted
      acq_list = {};
      for (int r = 0; r < MAXR; r++) acq_list.push_back(32'h8000_0000 | ($urandom & 32'hFF));
      do_job("acq exhausted");

      // Timeout, event on the last cycle, event one cycle too late
      rand_regs();
      acq_list  = '{32'h0000_0022};
      evt_delay = 0;
      do_job("timeout");
      acq_list  = '{32'h0000_0023};
      evt_delay = TO;
      do_job("event on last cycle");
      acq_list  = '{32'h0000_0024};
      evt_delay = TO + 1;
      do_job("event after timeout");

      // Stale event during register writes is dropped
      stray_evt = 1;
      acq_list  = '{32'h0000_0055};
      evt_delay = 7;
      do_job("stray event");
      stray_evt = 0;

      // Response in the same cycle as the ACQUIRE grant
      same_cyc_rsp = 1;
      acq_list  = '{32'h0000_0066};
      evt_delay = 2;
      do_job("same-cycle response");
      if (trace.size() > 1)
         check("same-cycle first write cycle", 64'(trace[1].cyc - t_acc), 64'd2);
      same_cyc_rsp = 0;

      // Reset while a register write is waiting for grant
      gnt_mode = 2;
      rand_regs();
      acq_list  = '{32'h0000_0007};
      evt_delay = 2;
      start_job("reset");
      guard = 0;
      while (!(req && !wen) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("reset write pending", 64'(req && !wen), 64'd1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      check("reset mid-job req", 64'(req), 64'd0);
      check("reset mid-job ready", {job_ready, busy}, {1'b1, 1'b0});
      gnt_mode = 0;
      repeat (6) @(negedge clk);
      check("reset mid-job no done", 64'(dones.size()), 64'd0);
      rand_regs();
      acq_list  = '{32'h0000_0009};
      evt_delay = 4;
      do_job("after reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
